// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED serial transmitter.
// Contents:
//   oled_tx_state_t  - transmitter FSM state encoding
//   OLED_BYTE_BITS   - bits per transferred byte
//   OLED_CMD/DATA    - DnC levels for command and data bytes
package oled_pkg;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} oled_tx_state_t;

    localparam int unsigned OLED_BYTE_BITS = 8;
    localparam logic        OLED_CMD       = 1'b0;
    localparam logic        OLED_DATA      = 1'b1;

endpackage

// File: rtl/oled_spi_tx_if.sv
// Byte handshake between a byte source (display controller / CPU bus wrapper)
// and the OLED serial transmitter.
//   TxData  - byte to send
//   TxDnC   - 0 = command, 1 = data
//   TxValid - source has a byte
//   TxReady - transmitter takes the byte on this cycle if TxValid is high
interface oled_spi_tx_if;
    import oled_pkg::*;

    logic [OLED_BYTE_BITS-1:0] TxData;
    logic                      TxDnC;
    logic                      TxValid;
    logic                      TxReady;

    modport master (output TxData, output TxDnC, output TxValid, input TxReady);
    modport slave  (input TxData, input TxDnC, input TxValid, output TxReady);

endinterface

// File: rtl/oled_half_timer.sv
// Half-period timer for SCLK phases.
//   Clock    - system clock
//   nReset   - asynchronous active-low reset
//   load_i   - restart the phase; the count reloads to HALF_PERIOD-1
//   expire_o - high on the last cycle of the current phase
module oled_half_timer #(
    parameter int unsigned HALF_PERIOD = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic Clock,
    input  logic nReset,
    input  logic load_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] Reload = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A phase that was loaded with HALF_PERIOD-1 therefore lasts HALF_PERIOD cycles.
    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/oled_spi_tx.sv
// Write-only SPI mode-0 transmitter for the OLED panel.
// Bytes go out MSB first; bytes offered in the GAP cycle are burst without
// raising nCS.
//   Clock, nReset       - system clock, asynchronous active-low reset
//   tx (slave)          - TxData/TxDnC/TxValid in, TxReady out
//   Busy                - high whenever nCS is low
//   SCLK, SDIN, DnC, nCS - panel pins, all registered
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic           Clock,
    input  logic           nReset,
    oled_spi_tx_if.slave   tx,
    output logic           Busy,
    output logic           SCLK,
    output logic           SDIN,
    output logic           DnC,
    output logic           nCS
);

    localparam int unsigned BitCntW = $clog2(OLED_BYTE_BITS);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(OLED_BYTE_BITS - 1);

    oled_tx_state_t            state_q, state_d;
    logic [OLED_BYTE_BITS-1:0] shreg_q, shreg_d;
    logic [BitCntW-1:0]        bitcnt_q, bitcnt_d;
    logic                      sclk_q, sclk_d;
    logic                      sdin_q, sdin_d;
    logic                      dnc_q, dnc_d;
    logic                      ncs_q, ncs_d;
    logic                      ready_q, ready_d;
    logic                      accept;
    logic                      timer_load;
    logic                      expire;

    oled_half_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timer (
        .Clock    (Clock),
        .nReset   (nReset),
        .load_i   (timer_load),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        sclk_d     = sclk_q;
        sdin_d     = sdin_q;
        dnc_d      = dnc_q;
        ncs_d      = ncs_q;
        timer_load = 1'b0;
        // ready_q is only high in IDLE and GAP, so this is the handshake itself.
        accept     = tx.TxValid & ready_q;

        unique case (state_q)
            IDLE, GAP: begin
                if (accept) begin
                    ncs_d      = 1'b0;
                    dnc_d      = tx.TxDnC;
                    sdin_d     = tx.TxData[OLED_BYTE_BITS-1];
                    shreg_d    = tx.TxData;
                    bitcnt_d   = LastBit;
                    timer_load = 1'b1;
                    state_d    = LOW;
                end else if (state_q == GAP) begin
                    ncs_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (expire) begin
                    sclk_d     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (expire) begin
                    sclk_d     = 1'b0;
                    timer_load = 1'b1;
                    if (bitcnt_q != '0) begin
                        // SDIN moves together with the falling SCLK edge.
                        shreg_d  = {shreg_q[OLED_BYTE_BITS-2:0], 1'b0};
                        sdin_d   = shreg_q[OLED_BYTE_BITS-2];
                        bitcnt_d = bitcnt_q - BitCntW'(1);
                        state_d  = LOW;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == GAP);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sclk_q   <= 1'b0;
            sdin_q   <= 1'b0;
            dnc_q    <= 1'b0;
            ncs_q    <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
            sdin_q   <= sdin_d;
            dnc_q    <= dnc_d;
            ncs_q    <= ncs_d;
            ready_q  <= ready_d;
        end
    end

    assign tx.TxReady = ready_q;
    assign SCLK       = sclk_q;
    assign SDIN       = sdin_q;
    assign DnC        = dnc_q;
    assign nCS        = ncs_q;
    assign Busy       = ~ncs_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Self-checking bench for oled_spi_tx: one instance with HALF_PERIOD=1 and one
// with HALF_PERIOD=3. A pin-level monitor rebuilds bytes from SDIN at SCLK
// rising edges and compares them with a queue of accepted bytes.
module tb_oled_spi_tx;
    import oled_pkg::*;

    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    logic sclk0, sdin0, dnc0, ncs0, busy0;
    logic sclk1, sdin1, dnc1, ncs1, busy1;

    oled_spi_tx_if if0 ();
    oled_spi_tx_if if1 ();

    oled_spi_tx #(.HALF_PERIOD(1), .CNT_W(4)) u_dut0 (
        .Clock(clk), .nReset(rst0_n), .tx(if0), .Busy(busy0),
        .SCLK(sclk0), .SDIN(sdin0), .DnC(dnc0), .nCS(ncs0)
    );
    oled_spi_tx #(.HALF_PERIOD(3), .CNT_W(4)) u_dut1 (
        .Clock(clk), .nReset(rst1_n), .tx(if1), .Busy(busy1),
        .SCLK(sclk1), .SDIN(sdin1), .DnC(dnc1), .nCS(ncs1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: accepted {DnC, byte} per DUT, plus pin-level trackers.
    logic [8:0]  exp0[$];
    logic [8:0]  exp1[$];
    int          nbits[2], run[2], low_len[2], last_len[2], gap_pos[2];
    int          rises[2], bytes_done[2];
    logic [7:0]  acc[2], last_byte[2];
    logic        prev_sclk[2], prev_sdin[2], prev_dnc[2], prev_ncs[2], last_dnc_sent[2];

    function automatic int qsize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [8:0] qfront(input int k);
        return (k == 0) ? exp0[0] : exp1[0];
    endfunction

    task automatic clear_model(input int k);
        if (k == 0) exp0.delete(); else exp1.delete();
        nbits[k] = 0; run[k] = 0; low_len[k] = 0; acc[k] = '0;
        prev_sclk[k] = 1'b0; prev_sdin[k] = 1'b0; prev_dnc[k] = 1'b0;
        prev_ncs[k] = 1'b1; last_dnc_sent[k] = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        logic s, d, c, n, b, r, rn, gap, nb;
        logic [8:0] fr;
        int hp;
        for (int k = 0; k < 2; k++) begin
            s  = (k == 0) ? sclk0 : sclk1;
            d  = (k == 0) ? sdin0 : sdin1;
            c  = (k == 0) ? dnc0  : dnc1;
            n  = (k == 0) ? ncs0  : ncs1;
            b  = (k == 0) ? busy0 : busy1;
            r  = (k == 0) ? if0.TxReady : if1.TxReady;
            rn = (k == 0) ? rst0_n : rst1_n;
            hp = (k == 0) ? 1 : 3;
            if (!rn) continue;
            nb = !n;
            check("busy_vs_ncs", b, nb);
            if (n) begin
                check("idle_sclk", s, 1'b0);
                check("idle_ready", r, 1'b1);
                check("dnc_hold_idle", c, last_dnc_sent[k]);
                if (!prev_ncs[k]) last_len[k] = low_len[k];
                low_len[k] = 0;
                run[k] = 0;
            end else begin
                low_len[k]++;
                // GAP is the single cycle right after the falling edge of the 8th bit.
                gap = prev_sclk[k] && !s && (nbits[k] == 0);
                if (gap) gap_pos[k] = low_len[k] - 1;
                check("tx_ready", r, gap);
                if (c != prev_dnc[k]) check("dnc_change_sclk_low", s, 1'b0);
                if (s != prev_sclk[k]) begin
                    if (prev_sclk[k]) check("high_phase_len", run[k], hp);
                    else if (nbits[k] != 0) check("low_phase_len", run[k], hp);
                    run[k] = 1;
                end else begin
                    run[k]++;
                end
                if (s && prev_sclk[k] && (d != prev_sdin[k])) check("sdin_stable_high", d, prev_sdin[k]);
                if (s && !prev_sclk[k]) begin
                    rises[k]++;
                    check("sdin_stable_at_rise", d, prev_sdin[k]);
                    if (qsize(k) == 0) begin
                        check("unexpected_bit", 1, 0);
                    end else begin
                        fr = qfront(k);
                        check("dnc_at_rise", c, fr[8]);
                        acc[k] = {acc[k][6:0], d};
                        nbits[k]++;
                        if (nbits[k] == 8) begin
                            check("rx_byte", acc[k], fr[7:0]);
                            if (k == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
                            last_byte[k] = acc[k];
                            bytes_done[k]++;
                            nbits[k] = 0;
                        end
                    end
                end
            end
            prev_sclk[k] = s; prev_sdin[k] = d; prev_dnc[k] = c; prev_ncs[k] = n;
        end
    end

    task automatic drive(input int k, input logic [7:0] dat, input logic c, input logic v);
        if (k == 0) begin if0.TxData = dat; if0.TxDnC = c; if0.TxValid = v; end
        else begin if1.TxData = dat; if1.TxDnC = c; if1.TxValid = v; end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int k, input logic [7:0] dat, input logic c, input bit hold);
        int n;
        n = 0;
        drive(k, dat, c, 1'b1);
        while (((k == 0) ? if0.TxReady : if1.TxReady) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            check("send_timeout", 0, 1);
            drive(k, dat, c, 1'b0);
            return;
        end
        if (k == 0) exp0.push_back({c, dat}); else exp1.push_back({c, dat});
        @(negedge clk);
        last_dnc_sent[k] = c;
        if (!hold) drive(k, dat, c, 1'b0);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((qsize(k) != 0 || ((k == 0) ? ncs0 : ncs1) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        dnc;
        logic [7:0]  bits_exp;
        int          ncs_len;
        int          to_gap;
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int bad, r0, b0, sent0, sent1;
        logic [7:0] rd;
        logic rc;
        bit hold;

        tbl[0] = '{8'hA5, OLED_CMD,  8'b1010_0101, 17, 16};
        tbl[1] = '{8'h3C, OLED_DATA, 8'b0011_1100, 17, 16};
        tbl[2] = '{8'h00, OLED_CMD,  8'b0000_0000, 17, 16};
        tbl[3] = '{8'hFF, OLED_DATA, 8'b1111_1111, 17, 16};
        tbl[4] = '{8'h80, OLED_CMD,  8'b1000_0000, 17, 16};

        for (int k = 0; k < 2; k++) begin
            clear_model(k);
            rises[k] = 0; bytes_done[k] = 0; last_len[k] = 0; gap_pos[k] = 0; last_byte[k] = '0;
        end
        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);
        rst0_n = 1'b0; rst1_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ncs", ncs0, 1'b1);
        check("rst_sclk", sclk0, 1'b0);
        check("rst_sdin", sdin0, 1'b0);
        check("rst_dnc", dnc0, 1'b0);
        check("rst_ready", if0.TxReady, 1'b1);
        check("rst_busy", busy0, 1'b0);
        rst0_n = 1'b1; rst1_n = 1'b1;

        // Idle: no traffic for 1000 cycles.
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sclk0 !== 1'b0 || sdin0 !== 1'b0 || ncs0 !== 1'b1) bad++;
            if (sclk1 !== 1'b0 || sdin1 !== 1'b0 || ncs1 !== 1'b1) bad++;
        end
        check("idle_1000_cycles", bad, 0);

        // Table of single frames on the HALF_PERIOD=1 instance.
        foreach (tbl[i]) begin
            r0 = rises[0];
            send(0, tbl[i].data, tbl[i].dnc, 1'b0);
            wait_idle(0);
            check("tbl_byte", last_byte[0], tbl[i].bits_exp);
            check("tbl_ncs_low", last_len[0], tbl[i].ncs_len);
            check("tbl_accept_to_gap", gap_pos[0], tbl[i].to_gap);
            check("tbl_rises", rises[0] - r0, 8);
            check("tbl_dnc_after", dnc0, tbl[i].dnc);
        end

        // Burst: command then data with TxValid held high.
        r0 = rises[0];
        send(0, 8'h81, OLED_CMD, 1'b1);
        send(0, 8'hFF, OLED_DATA, 1'b0);
        wait_idle(0);
        check("burst_ncs_low", last_len[0], 34);
        check("burst_accept_to_gap", gap_pos[0], 33);
        check("burst_rises", rises[0] - r0, 16);
        check("burst_last", last_byte[0], 8'hFF);

        // New byte offered while busy; TxData wiggles mid-byte beforehand.
        b0 = bytes_done[0];
        send(0, 8'hC3, OLED_DATA, 1'b0);
        repeat (4) @(negedge clk);
        drive(0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("ready_while_busy", if0.TxReady, 1'b0);
        send(0, 8'h3C, OLED_CMD, 1'b0);
        wait_idle(0);
        check("pending_bytes", bytes_done[0] - b0, 2);
        check("pending_last", last_byte[0], 8'h3C);
        check("pending_ncs_low", last_len[0], 34);

        // Asynchronous reset in the middle of 0xF0.
        r0 = rises[0];
        send(0, 8'hF0, OLED_CMD, 1'b0);
        bad = 0;
        while (rises[0] < r0 + 4 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        check("rst_mid_reach", (rises[0] >= r0 + 4) ? 1 : 0, 1);
        #2 rst0_n = 1'b0;
        #1;
        check("async_rst_ncs", ncs0, 1'b1);
        check("async_rst_sclk", sclk0, 1'b0);
        check("async_rst_sdin", sdin0, 1'b0);
        check("async_rst_ready", if0.TxReady, 1'b1);
        check("async_rst_busy", busy0, 1'b0);
        clear_model(0);
        #1 rst0_n = 1'b1;
        @(negedge clk);
        b0 = bytes_done[0];
        send(0, 8'h0F, OLED_DATA, 1'b0);
        wait_idle(0);
        check("post_rst_byte", last_byte[0], 8'h0F);
        check("post_rst_count", bytes_done[0] - b0, 1);

        // HALF_PERIOD=3 instance.
        r0 = rises[1];
        send(1, 8'h55, OLED_CMD, 1'b0);
        wait_idle(1);
        check("hp3_byte", last_byte[1], 8'h55);
        check("hp3_accept_to_gap", gap_pos[1], 48);
        check("hp3_ncs_low", last_len[1], 49);
        check("hp3_rises", rises[1] - r0, 8);

        // Randomised traffic with bursts and idle gaps.
        sent0 = 0; sent1 = 0;
        r0 = bytes_done[0];
        b0 = bytes_done[1];
        for (int i = 0; i < 60; i++) begin
            rd   = 8'($urandom);
            rc   = 1'($urandom);
            hold = ($urandom_range(0, 2) == 0) && (i != 39) && (i != 59);
            if (i < 40) begin send(0, rd, rc, hold); sent0++; end
            else begin send(1, rd, rc, hold); sent1++; end
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0);
        wait_idle(1);
        check("rand_bytes_dut0", bytes_done[0] - r0, sent0);
        check("rand_bytes_dut1", bytes_done[1] - b0, sent1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
